// File: rtl/ram_pkg.sv
// Shared definitions for the CPU data memories: default geometry, sweep state
// encoding and the depth helper.
package ram_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_ADDR_WIDTH = 14;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } sweep_state_e;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/ram_sweep_fsm.sv
// Clear-sweep controller: walks every address once after reset or on request
// and reports busy / a one-cycle done pulse.
module ram_sweep_fsm
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic                  o_clear_done,
   output logic                  o_sweep_we,
   output logic [ADDR_WIDTH-1:0] o_sweep_addr,
   output sweep_state_e          o_state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   sweep_state_e          r_state;
   sweep_state_e          w_next_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] w_next_ptr;
   logic                  r_clear_done;
   logic                  w_next_done;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= CLEAR;
         r_ptr        <= '0;
         r_clear_done <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_ptr        <= w_next_ptr;
         r_clear_done <= w_next_done;
      end
   end

   // Requests arriving while a sweep is running are ignored, not restarted.
   always_comb begin
      w_next_state = r_state;
      w_next_ptr   = r_ptr;
      w_next_done  = 1'b0;
      case (r_state)
         IDLE: begin
            w_next_ptr = '0;
            if (i_clear) begin
               w_next_state = CLEAR;
            end
         end
         CLEAR: begin
            w_next_ptr = r_ptr + ADDR_WIDTH'(1);
            if (r_ptr == LAST_ADDR) begin
               w_next_state = IDLE;
               w_next_done  = 1'b1;
            end
         end
         default: begin
            w_next_state = CLEAR;
            w_next_ptr   = '0;
         end
      endcase
   end

   always_comb begin
      o_busy       = (r_state == CLEAR);
      o_sweep_we   = (r_state == CLEAR);
      o_sweep_addr = r_ptr;
      o_clear_done = r_clear_done;
      o_state      = r_state;
   end

endmodule

// File: rtl/ram_clear.sv
// Single-port data RAM with synchronous write, combinational read and a
// hardware clear sweep that owns the write port while it runs.
module ram_clear
   import ram_pkg::*;
#(
   parameter int                 WIDTH       = DEF_WIDTH,
   parameter int                 ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter logic [WIDTH-1:0]   CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      in,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  clear,
   output logic [WIDTH-1:0]      out,
   output logic                  busy,
   output logic                  clear_done
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic                  w_busy;
   logic                  w_sweep_we;
   logic [ADDR_WIDTH-1:0] w_sweep_addr;
   sweep_state_e          w_state;
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [WIDTH-1:0]      w_wr_data;

   ram_sweep_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sweep (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_clear      (clear),
      .o_busy       (w_busy),
      .o_clear_done (clear_done),
      .o_sweep_we   (w_sweep_we),
      .o_sweep_addr (w_sweep_addr),
      .o_state      (w_state)
   );

   // Sweep has priority; user writes during a sweep are dropped.
   assign w_wr_en   = w_sweep_we | load;
   assign w_wr_addr = w_sweep_we ? w_sweep_addr : address;
   assign w_wr_data = w_sweep_we ? CLEAR_VALUE : in;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= w_wr_data;
      end
   end

   assign busy = w_busy;
   assign out  = (w_state == CLEAR) ? CLEAR_VALUE : r_mem[address];

endmodule

// File: tb/tb_ram_clear.sv
// Bench for ram_clear: two instances (clear value 0 and A5A5) share stimulus;
// read data is checked against a queued expectation from a memory model.
module tb_ram_clear;

   localparam int            W    = 16;
   localparam int            AW   = 4;
   localparam int            D    = 16;
   localparam logic [W-1:0]  CV_A = 16'h0000;
   localparam logic [W-1:0]  CV_B = 16'hA5A5;

   logic          clk   = 1'b0;
   logic          reset = 1'b0;
   logic          load  = 1'b0;
   logic          clear = 1'b0;
   logic [W-1:0]  din   = '0;
   logic [AW-1:0] addr  = '0;
   logic [W-1:0]  out_a, out_b;
   logic          busy_a, busy_b, done_a, done_b;

   logic [W-1:0]   ma [D];
   logic [W-1:0]   mb [D];
   logic [2*W-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_clear #(.WIDTH(W), .ADDR_WIDTH(AW), .CLEAR_VALUE(CV_A)) dut_a (
      .clk(clk), .reset(reset), .in(din), .load(load), .address(addr),
      .clear(clear), .out(out_a), .busy(busy_a), .clear_done(done_a)
   );

   ram_clear #(.WIDTH(W), .ADDR_WIDTH(AW), .CLEAR_VALUE(CV_B)) dut_b (
      .clk(clk), .reset(reset), .in(din), .load(load), .address(addr),
      .clear(clear), .out(out_b), .busy(busy_b), .clear_done(done_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_swept();
      for (int i = 0; i < D; i++) begin
         ma[i] = CV_A;
         mb[i] = CV_B;
      end
   endtask

   task automatic read_word(input int a);
      logic [2*W-1:0] e;
      addr = AW'(a);
      load = 1'b0;
      exp_q.push_back({ma[a], mb[a]});
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq("rd_a", 32'(out_a), 32'(e[2*W-1:W]));
      check_eq("rd_b", 32'(out_b), 32'(e[W-1:0]));
      tick();
   endtask

   task automatic read_all();
      for (int a = 0; a < D; a++) read_word(a);
   endtask

   task automatic write_word(input int a, input logic [W-1:0] v);
      addr = AW'(a);
      din  = v;
      load = 1'b1;
      tick();
      load  = 1'b0;
      ma[a] = v;
      mb[a] = v;
   endtask

   // Entered just after the edge that starts a sweep; returns in the done cycle.
   task automatic watch_sweep(input string tag, input int load_at, input int clear_at,
                              input int reset_at);
      int nb;
      nb = (reset_at >= 0) ? reset_at + 1 + D : D;
      for (int i = 0; i < nb; i++) begin
         if (i == load_at) begin
            addr = 4'd3;
            din  = 16'h1234;
            load = 1'b1;
         end
         clear = (i == clear_at);
         reset = (i == reset_at);
         @(negedge clk);
         check_eq({tag, "_busy_a"}, 32'(busy_a), 32'd1);
         check_eq({tag, "_busy_b"}, 32'(busy_b), 32'd1);
         check_eq({tag, "_nodone"}, 32'(done_a), 32'd0);
         check_eq({tag, "_out_a"}, 32'(out_a), 32'(CV_A));
         check_eq({tag, "_out_b"}, 32'(out_b), 32'(CV_B));
         tick();
         load  = 1'b0;
         clear = 1'b0;
         reset = 1'b0;
      end
      @(negedge clk);
      check_eq({tag, "_end_busy"}, 32'(busy_a), 32'd0);
      check_eq({tag, "_done_a"}, 32'(done_a), 32'd1);
      check_eq({tag, "_done_b"}, 32'(done_b), 32'd1);
      model_swept();
   endtask

   initial begin
      // Power-on sweep
      reset = 1'b1;
      tick();
      reset = 1'b0;
      watch_sweep("por", -1, -1, -1);
      tick();
      check_eq("por_done_clr", 32'(done_a), 32'd0);
      read_all();

      // Write then read; old data visible during the write cycle
      addr = 4'd5;
      din  = 16'hBEEF;
      load = 1'b1;
      @(negedge clk);
      check_eq("rdw_old", 32'(out_b), 32'(mb[5]));
      tick();
      load  = 1'b0;
      ma[5] = 16'hBEEF;
      mb[5] = 16'hBEEF;
      read_word(5);
      read_word(6);

      // Fill with address, then requested sweep with a dropped mid-sweep load
      for (int a = 0; a < D; a++) write_word(a, W'(a));
      read_all();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      watch_sweep("req", 3, -1, -1);
      tick();
      read_all();

      // Simultaneous load + clear in IDLE
      addr  = 4'd2;
      din   = 16'h7777;
      load  = 1'b1;
      clear = 1'b1;
      tick();
      load  = 1'b0;
      clear = 1'b0;
      watch_sweep("ldclr", -1, -1, -1);
      tick();
      read_word(2);

      // Reset in the middle of a sweep restarts it
      write_word(7, 16'h1111);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      watch_sweep("rstmid", -1, -1, 9);
      tick();
      read_all();

      // Re-request during a sweep is ignored; load in the done cycle is accepted
      clear = 1'b1;
      tick();
      clear = 1'b0;
      watch_sweep("reclr", -1, 4, -1);
      addr = 4'd9;
      din  = 16'h4321;
      load = 1'b1;
      tick();
      load  = 1'b0;
      ma[9] = 16'h4321;
      mb[9] = 16'h4321;
      @(negedge clk);
      check_eq("reclr_one_pulse", 32'(done_a), 32'd0);
      tick();
      read_word(9);
      read_word(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
